// File: rtl/ibex_fp_wb_arbiter_if.sv
// Bus bundle for the FP write-back arbiter: FPU result handshake, LSU load
// return, the register file write port and the hazard-side status outputs.
// Signal names carry their direction as seen from the arbiter.
interface ibex_fp_wb_arbiter_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 fpu_valid_i;
  logic                 fpu_ready_o;
  logic [4:0]           fpu_waddr_i;
  logic [DataWidth-1:0] fpu_wdata_i;
  logic                 lsu_valid_i;
  logic [4:0]           lsu_waddr_i;
  logic [DataWidth-1:0] lsu_wdata_i;
  logic                 fp_we_a_o;
  logic [4:0]           fp_waddr_a_o;
  logic [DataWidth-1:0] fp_wdata_a_o;
  logic [31:0]          pending_o;
  logic                 busy_o;
  logic                 err_o;

  // Producer / consumer side (FPU, LSU, register file, hazard logic).
  modport master (
    output fpu_valid_i, fpu_waddr_i, fpu_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  fpu_ready_o, fp_we_a_o, fp_waddr_a_o, fp_wdata_a_o,
    input  pending_o, busy_o, err_o
  );

  // Arbiter side.
  modport slave (
    input  fpu_valid_i, fpu_waddr_i, fpu_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output fpu_ready_o, fp_we_a_o, fp_waddr_a_o, fp_wdata_a_o,
    output pending_o, busy_o, err_o
  );
endinterface

// File: rtl/ibex_fp_wb_arbiter.sv
// FP register file write-back arbiter. LSU load returns cannot stall and always
// win the single write port; FPU results queue in a small in-order FIFO and
// drain whenever the LSU is idle. The write port is driven from registers.
module ibex_fp_wb_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 2
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  ibex_fp_wb_arbiter_if.slave bus
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(FifoDepth - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FifoDepth);

  typedef struct packed {
    logic [4:0]           waddr;
    logic [DataWidth-1:0] wdata;
  } entry_t;

  // Pointers wrap at FifoDepth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    logic [PtrW-1:0] nxt;
    if (ptr == PtrLast) begin
      nxt = {PtrW{1'b0}};
    end else begin
      nxt = ptr + {{(PtrW-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

  entry_t                 mem_q [FifoDepth];
  logic [FifoDepth-1:0]   valid_q, valid_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   we_q, we_d;
  logic [4:0]             waddr_q, waddr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic                   err_q, err_d;

  logic                   ready_s;
  logic                   push_s;
  logic                   pop_s;
  logic [31:0]            fifo_pend_s;

  assign ready_s = (count_q < CntFull);
  assign push_s  = bus.fpu_valid_i && ready_s;
  assign pop_s   = !bus.lsu_valid_i && (count_q != {CntW{1'b0}});

  // Destination registers currently waiting in the FIFO.
  always_comb begin
    fifo_pend_s = 32'd0;
    for (int i = 0; i < int'(FifoDepth); i++) begin
      if (valid_q[i]) begin
        fifo_pend_s[mem_q[i].waddr] = 1'b1;
      end else begin
        fifo_pend_s = fifo_pend_s;
      end
    end
  end

  // FIFO bookkeeping, port selection (LSU first) and sticky ordering error.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    valid_d  = valid_q;
    count_d  = count_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    if (pop_s) begin
      rd_ptr_d          = ptr_inc(rd_ptr_q);
      valid_d[rd_ptr_q] = 1'b0;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s) begin
      wr_ptr_d          = ptr_inc(wr_ptr_q);
      valid_d[wr_ptr_q] = 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{(CntW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CntW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase

    if (bus.lsu_valid_i) begin
      we_d    = 1'b1;
      waddr_d = bus.lsu_waddr_i;
      wdata_d = bus.lsu_wdata_i;
    end else if (pop_s) begin
      we_d    = 1'b1;
      waddr_d = mem_q[rd_ptr_q].waddr;
      wdata_d = mem_q[rd_ptr_q].wdata;
    end else begin
      we_d = 1'b0;
    end

    // An LSU write overtaking a queued FPU write to the same register.
    err_d = err_q | (bus.lsu_valid_i & fifo_pend_s[bus.lsu_waddr_i]);
  end

  // State registers; reset discards queued entries and any registered write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FifoDepth); i++) begin
        mem_q[i] <= '0;
      end
      valid_q  <= {FifoDepth{1'b0}};
      rd_ptr_q <= {PtrW{1'b0}};
      wr_ptr_q <= {PtrW{1'b0}};
      count_q  <= {CntW{1'b0}};
      we_q     <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= {DataWidth{1'b0}};
      err_q    <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= '{waddr: bus.fpu_waddr_i, wdata: bus.fpu_wdata_i};
      end
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.fpu_ready_o  = ready_s;
  assign bus.fp_we_a_o    = we_q;
  assign bus.fp_waddr_a_o = waddr_q;
  assign bus.fp_wdata_a_o = wdata_q;
  assign bus.pending_o    = fifo_pend_s | (we_q ? (32'd1 << waddr_q) : 32'd0);
  assign bus.busy_o       = (count_q != {CntW{1'b0}}) || we_q;
  assign bus.err_o        = err_q;

endmodule

// File: doc/ibex_fp_wb_arbiter.md
# ibex_fp_wb_arbiter

Write-back arbiter and buffer directly upstream of the FP register file's single write port. It merges FP load returns from the LSU with results from the multi-cycle FPU. LSU returns cannot be stalled, so they always win. FPU results wait in a small in-order FIFO with a valid/ready handshake. The block drives the register file's write port from registered outputs and exports a pending-write mask for hazard logic.

## Interface
- DataWidth, 32, width of one FP register
- FifoDepth, 2, FPU result FIFO entries (>= 1)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- fpu_valid_i  in  1  FPU result valid
- fpu_ready_o  out  1  FIFO can accept an FPU result this cycle
- fpu_waddr_i  in  5  FPU destination register
- fpu_wdata_i  in  DataWidth  FPU result data
- lsu_valid_i  in  1  FP load return valid (never stalled)
- lsu_waddr_i  in  5  load destination register
- lsu_wdata_i  in  DataWidth  load data
- fp_we_a_o  out  1  register file write enable
- fp_waddr_a_o  out  5  register file write address
- fp_wdata_a_o  out  DataWidth  register file write data
- pending_o  out  32  bit k set while a write to register k sits in the FIFO or the output register
- busy_o  out  1  FIFO non-empty or fp_we_a_o high
- err_o  out  1  sticky ordering-violation flag

## Operation
- FIFO: circular, read pointer, write pointer and count in 0..FifoDepth. Pointers wrap modulo FifoDepth.
- fpu_ready_o = (count < FifoDepth). It depends only on registered state, not on the pop in the same cycle.
- Push on fpu_valid_i && fpu_ready_o. Each entry holds {waddr, wdata}.
- Selection each cycle:
  - lsu_valid_i=1 → select LSU; FIFO does not pop.
  - Otherwise, count>0 → select and pop FIFO head.
  - Otherwise → no write.
- Selected write is registered into fp_we_a_o/fp_waddr_a_o/fp_wdata_a_o at the next edge. With no selection, fp_we_a_o=0 and address/data hold their previous values.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- pending_o = OR over valid FIFO entries of onehot(waddr), OR onehot(fp_waddr_a_o) when fp_we_a_o=1. Register 0 is an ordinary FP register and is not special.
- Duplicate FIFO addresses are legal and retire in push order.
- err_o: set when lsu_valid_i=1 and pending bit lsu_waddr_i is set from a FIFO entry. LSU priority would reorder those writes, so this is a hazard-logic violation. It stays sticky until reset. The LSU write still proceeds.
- LSU back-to-back for any number of cycles starves the FIFO. fpu_ready_o then falls when the FIFO is full; no data is lost.

## Timing
- Reset (async assert, state cleared immediately):
  - count=0, pointers=0, err_o=0.
  - fp_we_a_o=0, fp_waddr_a_o=0, fp_wdata_a_o=0.
  - pending_o=0, busy_o=0, fpu_ready_o=1.
- Reset asserted mid-operation discards all FIFO contents and any registered write.
- LSU latency: lsu_valid_i in cycle N → fp_we_a_o=1 in cycle N+1.
- FPU latency with no LSU contention: push in cycle N → head in N+1 → fp_we_a_o=1 in N+2.
- Sustained throughput is one write per cycle.
- pending_o and busy_o are combinational from registered state only.

## Test plan
- Reset, then FPU push waddr=3, wdata=0x3F800000 in cycle 0 → fp_we_a_o=1, waddr 3, data 0x3F800000 in cycle 2. pending_o[3]=1 in cycles 1–2, 0 in cycle 3.
- lsu_valid_i waddr=5 and fpu_valid_i waddr=6 in the same cycle N → reg 5 written in N+1, reg 6 in N+2, err_o=0.
- lsu_valid_i held 4 cycles while FPU pushes every cycle (FifoDepth=2) → fpu_ready_o=0 after 2 accepted pushes. LSU releases → both entries retire in order on consecutive cycles, then ready returns to 1.
- FPU pushes waddr=7 every cycle for 5 cycles, no LSU → 5 consecutive writes to reg 7 with data in push order, fpu_ready_o never drops.
- FIFO holds waddr=9, then lsu_valid_i waddr=9 → err_o=1 from the next cycle and stays 1 until rst_ni pulses low.
- rst_ni dropped asynchronously with 2 FIFO entries pending → outputs and pending_o clear immediately; no write after release.
